fifo8_class: RTL and testbench

FIFO8_CLASS -- requirements
Module: fifo8_class

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_mem_2p.sv | 26 ++
 rtl/fifo8_class.sv | 86 ++++++++
 tb/tb_fifo8_class.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the class FIFO and its storage.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: one write port, one registered read port, no reset.
module fifo_mem_2p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Same-edge read of a slot being written returns the old contents.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo8_class.sv
// Per-class FIFO with registered read data and occupancy flags.
// Define FIFO_ERR_STICKY_EN to make fifo_error hold until reset instead of pulsing.
module fifo8_class
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AF_TH  = 3,
    parameter int AE_TH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              fifo_error
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop_ok, push_ok, err_evt;
    logic              have_read;
    logic [DATA_W-1:0] rd_data;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CNT_MAX) || pop_ok);
    assign err_evt = (push && !push_ok) || (pop && !pop_ok);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            have_read <= 1'b0;
            fifo_error <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            valid_out <= pop_ok;
            if (pop_ok) have_read <= 1'b1;
`ifdef FIFO_ERR_STICKY_EN
            fifo_error <= fifo_error | err_evt;
`else
            fifo_error <= err_evt;
`endif
        end
    end

    // Storage has no reset, so data_out reads zero until the first pop after reset.
    assign data_out = have_read ? rd_data : '0;

    assign full         = (count == CNT_MAX);
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AF_TH));
    assign almost_empty = (count <= CNT_W'(AE_TH));

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok && reset),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok && reset),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fifo8_class.sv
// Directed bench for fifo8_class: fill, overflow, underflow, full push+pop, wrap, reset.
module tb_fifo8_class;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       valid_out, full, empty, almost_full, almost_empty, fifo_error;

    int total = 0;
    int bad   = 0;
    bit err_state = 1'b0;

`ifdef FIFO_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    always #5 clk = ~clk;

    fifo8_class #(.DATA_W(8), .DEPTH(4), .AF_TH(3), .AE_TH(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit p, input logic [7:0] d, input bit q);
        push = p; data_in = d; pop = q;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    // Expected error flag after a cycle with/without an error event.
    task automatic err_step(input bit ev);
        if (ev) err_state = 1'b1;
        else if (!STICKY) err_state = 1'b0;
    endtask

    task automatic flags(input string tag, input bit f, input bit e, input bit af, input bit ae);
        chk({tag, ".full"}, full, f);
        chk({tag, ".empty"}, empty, e);
        chk({tag, ".afull"}, almost_full, af);
        chk({tag, ".aempty"}, almost_empty, ae);
    endtask

    initial begin
        // reset
        reset = 1'b0;
        cyc(0, 8'h00, 0);
        cyc(1, 8'h99, 1);
        flags("rst", 0, 1, 0, 1);
        chk("rst.valid", valid_out, 0);
        chk("rst.data", data_out, 8'h00);
        chk("rst.err", fifo_error, 0);
        reset = 1'b1;

        // three pushes
        cyc(1, 8'hA1, 0);
        flags("p1", 0, 0, 0, 1);
        cyc(1, 8'hB2, 0);
        flags("p2", 0, 0, 0, 0);
        cyc(1, 8'hC3, 0);
        flags("p3", 0, 0, 1, 0);
        chk("p3.valid", valid_out, 0);

        // fill and overflow
        cyc(1, 8'hD4, 0);
        flags("p4", 1, 0, 1, 0);
        chk("p4.err", fifo_error, 0);
        cyc(1, 8'hFF, 0);
        err_step(1);
        flags("ovf", 1, 0, 1, 0);
        chk("ovf.err", fifo_error, err_state);
        chk("ovf.valid", valid_out, 0);

        cyc(0, 8'h00, 1);
        err_step(0);
        chk("ovf.pop0.valid", valid_out, 1);
        chk("ovf.pop0.data", data_out, 8'hA1);
        chk("ovf.pop0.err", fifo_error, err_state);
        cyc(0, 8'h00, 1);
        chk("ovf.pop1.data", data_out, 8'hB2);
        cyc(0, 8'h00, 1);
        chk("ovf.pop2.data", data_out, 8'hC3);
        cyc(0, 8'h00, 1);
        chk("ovf.pop3.data", data_out, 8'hD4);
        chk("ovf.pop3.valid", valid_out, 1);
        flags("drained", 0, 1, 0, 1);

        // underflow
        cyc(0, 8'h00, 1);
        err_step(1);
        chk("udf.err", fifo_error, err_state);
        chk("udf.valid", valid_out, 0);
        chk("udf.data", data_out, 8'hD4);
        cyc(0, 8'h00, 0);
        err_step(0);
        chk("udf.idle.err", fifo_error, err_state);

        // simultaneous push/pop at full
        cyc(1, 8'h11, 0);
        cyc(1, 8'h22, 0);
        cyc(1, 8'h33, 0);
        cyc(1, 8'h44, 0);
        flags("full4", 1, 0, 1, 0);
        cyc(1, 8'h55, 1);
        err_step(0);
        chk("pp.valid", valid_out, 1);
        chk("pp.data", data_out, 8'h11);
        chk("pp.err", fifo_error, err_state);
        flags("pp", 1, 0, 1, 0);
        cyc(0, 8'h00, 1);
        chk("pp.pop1", data_out, 8'h22);
        cyc(0, 8'h00, 1);
        chk("pp.pop2", data_out, 8'h33);
        cyc(0, 8'h00, 1);
        chk("pp.pop3", data_out, 8'h44);
        cyc(0, 8'h00, 1);
        chk("pp.pop4", data_out, 8'h55);
        flags("pp.end", 0, 1, 0, 1);

        // ten push/pop pairs across pointer wrap
        cyc(1, 8'h60, 0);
        flags("wrap.pre", 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'h61 + 8'(i), 1);
            chk($sformatf("wrap%0d.valid", i), valid_out, 1);
            chk($sformatf("wrap%0d.data", i), data_out, 8'h60 + 8'(i));
            if (i % 2 == 0) begin
                cyc(0, 8'h00, 0);
                chk($sformatf("wrap%0d.idle.valid", i), valid_out, 0);
                chk($sformatf("wrap%0d.idle.data", i), data_out, 8'h60 + 8'(i));
            end
        end
        flags("wrap.cnt1", 0, 0, 0, 1);
        cyc(0, 8'h00, 1);
        chk("wrap.last", data_out, 8'h6A);
        chk("wrap.empty", empty, 1);
        err_step(0);
        chk("wrap.err", fifo_error, err_state);

        // reset with two entries held
        cyc(1, 8'h77, 0);
        cyc(1, 8'h88, 0);
        flags("pre_rst", 0, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 8'h00, 0);
        reset = 1'b1;
        err_state = 1'b0;
        flags("mid_rst", 0, 1, 0, 1);
        chk("mid_rst.valid", valid_out, 0);
        chk("mid_rst.data", data_out, 8'h00);
        chk("mid_rst.err", fifo_error, 0);
        cyc(0, 8'h00, 1);
        err_step(1);
        chk("post_rst.err", fifo_error, err_state);
        chk("post_rst.valid", valid_out, 0);
        chk("post_rst.data", data_out, 8'h00);

        // push+pop on empty: push only
        cyc(1, 8'h5A, 1);
        err_step(1);
        chk("e_pp.err", fifo_error, err_state);
        chk("e_pp.valid", valid_out, 0);
        flags("e_pp", 0, 0, 0, 1);
        cyc(0, 8'h00, 1);
        chk("e_pp.pop", data_out, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
